// File: rtl/snake_pkg.sv
// Shared definitions for the snake game step sequencer: status encodings,
// step FSM states and default timing constants.
package snake_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b01;
    localparam logic [1:0] ST_DIE     = 2'b10;
    localparam logic [1:0] ST_RESTART = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_MOVE,
        S_CHECK,
        S_GROW,
        S_DEAD
    } step_state_e;

    localparam int unsigned DEF_BASE_PERIOD = 25_000_000;
    localparam int unsigned DEF_MIN_PERIOD  = 6_250_000;
    localparam int unsigned DEF_SPEEDUP     = 500_000;
    localparam int unsigned WD_LIMIT        = 255;

endpackage

// File: rtl/step_period_calc.sv
// Move-period computation: base period shortened by score, floored at the
// minimum, optionally doubled (saturating) for slow mode.
module step_period_calc
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned SPEEDUP     = DEF_SPEEDUP,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic [SCORE_W-1:0] score,
    input  logic               slow_req,
    output logic [31:0]        period
);

    logic [63:0] removed;
    logic [31:0] base_p;
    logic [32:0] doubled;

    // The 64-bit product makes an oversized speed-up clamp instead of wrapping.
    always_comb begin
        removed = 64'(score) * 64'(SPEEDUP);
        if (removed >= 64'(BASE_PERIOD)) begin
            base_p = MIN_PERIOD;
        end else begin
            base_p = BASE_PERIOD - removed[31:0];
        end
        if (base_p < MIN_PERIOD) begin
            base_p = MIN_PERIOD;
        end
        doubled = {base_p, 1'b0};
        if (!slow_req) begin
            period = base_p;
        end else if (doubled[32]) begin
            period = '1;
        end else begin
            period = doubled[31:0];
        end
    end

endmodule

// File: rtl/step_scheduler.sv
// Game-step sequencer: move tick, move/collision/grow handshakes and score.
// Optional handshake watchdog enabled by defining STEP_WATCHDOG_EN.
module step_scheduler
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned SPEEDUP     = DEF_SPEEDUP,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         game_status,
    input  logic               slow_req,
    output logic               move_req,
    input  logic               move_ack,
    input  logic               collide,
    input  logic               ate,
    output logic               apple_req,
    input  logic               apple_ack,
    output logic               add_cube,
    output logic               die_req,
    output logic [SCORE_W-1:0] score,
    output logic [31:0]        period,
    output logic               fault
);

    step_state_e state;
    logic [31:0] tick_cnt;
    logic [31:0] next_period;
    logic        collide_q;
    logic        ate_q;

    step_period_calc #(
        .BASE_PERIOD(BASE_PERIOD),
        .MIN_PERIOD (MIN_PERIOD),
        .SPEEDUP    (SPEEDUP),
        .SCORE_W    (SCORE_W)
    ) u_period (
        .score   (score),
        .slow_req(slow_req),
        .period  (next_period)
    );

`ifdef STEP_WATCHDOG_EN
    logic [7:0] wd_cnt;
    logic       fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Restart overrides every state; otherwise leaving play aborts waits and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            move_req  <= 1'b0;
            apple_req <= 1'b0;
            add_cube  <= 1'b0;
            die_req   <= 1'b0;
            score     <= '0;
            period    <= BASE_PERIOD;
            tick_cnt  <= '0;
            collide_q <= 1'b0;
            ate_q     <= 1'b0;
`ifdef STEP_WATCHDOG_EN
            wd_cnt    <= '0;
            fault_q   <= 1'b0;
`endif
        end else begin
            add_cube <= 1'b0;
            die_req  <= 1'b0;
`ifdef STEP_WATCHDOG_EN
            wd_cnt   <= '0;
`endif
            if (game_status == ST_RESTART) begin
                state     <= S_IDLE;
                score     <= '0;
                period    <= BASE_PERIOD;
                move_req  <= 1'b0;
                apple_req <= 1'b0;
`ifdef STEP_WATCHDOG_EN
                fault_q   <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (game_status == ST_PLAY) begin
                            period   <= next_period;
                            tick_cnt <= next_period - 32'd1;
                            state    <= S_WAIT_TICK;
                        end
                    end
                    S_WAIT_TICK: begin
                        if (game_status != ST_PLAY) begin
                            state <= S_IDLE;
                        end else if (tick_cnt == 32'd0) begin
                            move_req <= 1'b1;
                            state    <= S_MOVE;
                        end else begin
                            tick_cnt <= tick_cnt - 32'd1;
                        end
                    end
                    S_MOVE: begin
                        if (game_status != ST_PLAY) begin
                            move_req <= 1'b0;
                            state    <= S_IDLE;
                        end else if (move_ack) begin
                            collide_q <= collide;
                            ate_q     <= ate;
                            move_req  <= 1'b0;
                            state     <= S_CHECK;
`ifdef STEP_WATCHDOG_EN
                        end else if (wd_cnt == 8'(WD_LIMIT - 1)) begin
                            fault_q  <= 1'b1;
                            die_req  <= 1'b1;
                            move_req <= 1'b0;
                            state    <= S_DEAD;
                        end else begin
                            wd_cnt <= wd_cnt + 8'd1;
`endif
                        end
                    end
                    S_CHECK: begin
                        if (collide_q) begin
                            die_req <= 1'b1;
                            state   <= S_DEAD;
                        end else if (ate_q) begin
                            add_cube  <= 1'b1;
                            apple_req <= 1'b1;
                            if (score != '1) begin
                                score <= score + 1'b1;
                            end
                            state <= S_GROW;
                        end else begin
                            period   <= next_period;
                            tick_cnt <= next_period - 32'd1;
                            state    <= S_WAIT_TICK;
                        end
                    end
                    S_GROW: begin
                        if (game_status != ST_PLAY) begin
                            apple_req <= 1'b0;
                            state     <= S_IDLE;
                        end else if (apple_ack) begin
                            apple_req <= 1'b0;
                            period    <= next_period;
                            tick_cnt  <= next_period - 32'd1;
                            state     <= S_WAIT_TICK;
`ifdef STEP_WATCHDOG_EN
                        end else if (wd_cnt == 8'(WD_LIMIT - 1)) begin
                            fault_q   <= 1'b1;
                            die_req   <= 1'b1;
                            apple_req <= 1'b0;
                            state     <= S_DEAD;
                        end else begin
                            wd_cnt <= wd_cnt + 8'd1;
`endif
                        end
                    end
                    S_DEAD: begin
                        move_req  <= 1'b0;
                        apple_req <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler: directed game steps plus a randomized
// run checked against a score/period model derived from the game rules.
module tb_step_scheduler;

    localparam int BASE = 20;
    localparam int MINP = 8;
    localparam int SPD  = 4;
    localparam int SW   = 8;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic [1:0]    game_status = 2'b00;
    logic          slow_req    = 1'b0;
    logic          move_ack    = 1'b0;
    logic          collide     = 1'b0;
    logic          ate         = 1'b0;
    logic          apple_ack   = 1'b0;
    logic          move_req;
    logic          apple_req;
    logic          add_cube;
    logic          die_req;
    logic [SW-1:0] score;
    logic [31:0]   period;
    logic          fault;

    int tests = 0;
    int failed = 0;
    int modelScore = 0;
    bit slowAtReload = 1'b0;

    step_scheduler #(
        .BASE_PERIOD(BASE),
        .MIN_PERIOD (MINP),
        .SPEEDUP    (SPD),
        .SCORE_W    (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_status(game_status),
        .slow_req   (slow_req),
        .move_req   (move_req),
        .move_ack   (move_ack),
        .collide    (collide),
        .ate        (ate),
        .apple_req  (apple_req),
        .apple_ack  (apple_ack),
        .add_cube   (add_cube),
        .die_req    (die_req),
        .score      (score),
        .period     (period),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Expected period from the game rules, in wide signed arithmetic.
    function automatic longint expPeriod(input int s, input bit slow);
        longint p;
        p = longint'(BASE) - longint'(s) * SPD;
        if (p < MINP) p = MINP;
        if (slow) p = p * 2;
        if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mack, input logic col, input logic at, input logic aack);
        move_ack  = mack;
        collide   = col;
        ate       = at;
        apple_ack = aack;
        tick();
    endtask

    task automatic waitMoveReq(output int n);
        n = 0;
        while (move_req !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    // One full game step, starting just after the edge that entered WAIT_TICK.
    task automatic runStep(input bit c, input bit a, input int md, input int ad, input bit sl, output bit died);
        int n;
        longint ep;
        ep = expPeriod(modelScore, slowAtReload);
        checkOutput("period", period, ep);
        waitMoveReq(n);
        checkOutput("tick_len", n, ep);
        repeat (md) applyStimulus(1'b0, c, a, 1'b0);
        checkOutput("move_req_hold", move_req, 1);
        slow_req = sl;
        applyStimulus(1'b1, c, a, 1'b0);
        checkOutput("move_req_drop", move_req, 0);
        applyStimulus(1'b0, c, a, 1'b0);
        died = 1'b0;
        if (c) begin
            checkOutput("die_req", die_req, 1);
            checkOutput("no_grow_on_die", add_cube, 0);
            checkOutput("score_on_die", score, modelScore);
            died = 1'b1;
        end else if (a) begin
            modelScore = (modelScore < 255) ? modelScore + 1 : 255;
            checkOutput("add_cube", add_cube, 1);
            checkOutput("score_inc", score, modelScore);
            checkOutput("apple_req_rise", apple_req, 1);
            checkOutput("no_die_on_eat", die_req, 0);
            repeat (ad) begin
                applyStimulus(1'b0, c, a, 1'b0);
                checkOutput("add_cube_once", add_cube, 0);
            end
            checkOutput("apple_req_hold", apple_req, 1);
            slowAtReload = sl;
            applyStimulus(1'b0, c, a, 1'b1);
            checkOutput("apple_req_drop", apple_req, 0);
            checkOutput("score_no_recount", score, modelScore);
        end else begin
            checkOutput("add_cube_idle", add_cube, 0);
            checkOutput("die_req_idle", die_req, 0);
            slowAtReload = sl;
        end
        move_ack  = 1'b0;
        apple_ack = 1'b0;
        collide   = 1'b0;
        ate       = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit hit");
    end

    initial begin
        bit died;
        int n;
        int dies;
        int faultAt;
        int faultSeen;

        // Reset values
        repeat (3) tick();
        checkOutput("rst_move_req", move_req, 0);
        checkOutput("rst_apple_req", apple_req, 0);
        checkOutput("rst_add_cube", add_cube, 0);
        checkOutput("rst_die_req", die_req, 0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_period", period, BASE);
        checkOutput("rst_fault", fault, 0);
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("idle_no_move", move_req, 0);

        // Basic ticks, eat with delayed apple ack, speed floor, slow mode, collision
        game_status = 2'b01;
        slowAtReload = slow_req;
        tick();
        runStep(1'b0, 1'b0, 2, 0, 1'b0, died);
        runStep(1'b0, 1'b1, 0, 5, 1'b0, died);
        runStep(1'b0, 1'b1, 1, 0, 1'b0, died);
        runStep(1'b0, 1'b1, 0, 2, 1'b0, died);
        runStep(1'b0, 1'b1, 0, 0, 1'b0, died);
        runStep(1'b0, 1'b1, 0, 1, 1'b0, died);
        runStep(1'b0, 1'b1, 0, 0, 1'b0, died);
        runStep(1'b0, 1'b0, 0, 0, 1'b1, died);
        runStep(1'b1, 1'b1, 0, 0, 1'b0, died);
        tick();
        checkOutput("die_req_pulse_end", die_req, 0);
        repeat (30) tick();
        checkOutput("dead_no_move", move_req, 0);
        checkOutput("dead_score_hold", score, modelScore);
        game_status = 2'b11;
        tick();
        modelScore = 0;
        checkOutput("restart_score", score, 0);
        checkOutput("restart_period", period, BASE);
        game_status = 2'b00;
        repeat (25) tick();
        checkOutput("restart_idle", move_req, 0);

        // Randomized steps against the model
        slow_req = 1'b0;
        game_status = 2'b01;
        slowAtReload = slow_req;
        tick();
        for (int i = 0; i < 24; i++) begin
            runStep(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)), died);
            if (died) begin
                tick();
                game_status = 2'b11;
                tick();
                modelScore = 0;
                checkOutput("rnd_restart_score", score, 0);
                game_status = 2'b01;
                slowAtReload = slow_req;
                tick();
            end
        end

        // Abort while move_req is high; a late ack must be ignored
        waitMoveReq(n);
        checkOutput("abort_tick_len", n, expPeriod(modelScore, slowAtReload));
        game_status = 2'b00;
        tick();
        checkOutput("abort_move_req", move_req, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("late_ack_grow", add_cube, 0);
        checkOutput("late_ack_die", die_req, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("late_ack_grow2", add_cube, 0);
        checkOutput("late_ack_die2", die_req, 0);
        checkOutput("abort_score_kept", score, modelScore);

        // Reset asserted while apple_req is pending
        game_status = 2'b01;
        slowAtReload = slow_req;
        tick();
        waitMoveReq(n);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_apple_req", apple_req, 1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_apple_req", apple_req, 0);
        checkOutput("mid_rst_add_cube", add_cube, 0);
        checkOutput("mid_rst_score", score, 0);
        checkOutput("mid_rst_period", period, BASE);
        rst = 1'b0;
        modelScore = 0;

        // Unacknowledged move request
        slow_req = 1'b0;
        slowAtReload = 1'b0;
        tick();
        waitMoveReq(n);
        checkOutput("wd_tick_len", n, BASE);
        dies = 0;
        faultAt = -1;
        faultSeen = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (die_req === 1'b1) dies++;
            if (fault === 1'b1) begin
                faultSeen++;
                if (faultAt < 0) faultAt = k;
            end
        end
`ifdef STEP_WATCHDOG_EN
        checkOutput("wd_fault_time", faultAt, 255);
        checkOutput("wd_die_pulses", dies, 1);
        checkOutput("wd_fault_sticky", fault, 1);
        checkOutput("wd_move_req_drop", move_req, 0);
`else
        checkOutput("nowd_fault", faultSeen, 0);
        checkOutput("nowd_die", dies, 0);
        checkOutput("nowd_move_req", move_req, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
